// File: rtl/int_priority_ctrl_pkg.sv
// Shared level encodings, default handler vectors and small mask helpers
// for the nested interrupt controller.
package int_pkg;

    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL1     = 2'd1;
    localparam logic [1:0] LVL2     = 2'd2;
    localparam logic [1:0] LVL3     = 2'd3;

    localparam logic [31:0] VEC1_DEF = 32'h0000_0100;
    localparam logic [31:0] VEC2_DEF = 32'h0000_0200;
    localparam logic [31:0] VEC3_DEF = 32'h0000_0300;

    // Bit (lvl-1) set for a real level; level 0 maps to an empty mask.
    function automatic logic [2:0] lvl_onehot(input logic [1:0] lvl);
        logic [2:0] oh;
        case (lvl)
            LVL1:    oh = 3'b001;
            LVL2:    oh = 3'b010;
            LVL3:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Levels strictly above lvl; only these may preempt.
    function automatic logic [2:0] above_mask(input logic [1:0] lvl);
        logic [2:0] m;
        case (lvl)
            LVL_NONE: m = 3'b111;
            LVL1:     m = 3'b110;
            LVL2:     m = 3'b100;
            default:  m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/int_priority_ctrl_enc.sv
// Highest-set-bit encoder: bit i of mask stands for level i+1; 0 when empty.
module int_prio_enc
    import int_pkg::*;
(
    input  logic [2:0] mask,
    output logic [1:0] level
);

    // Priority encode, level 3 wins.
    always_comb begin
        level = LVL_NONE;
        if (mask[2]) begin
            level = LVL3;
        end else if (mask[1]) begin
            level = LVL2;
        end else if (mask[0]) begin
            level = LVL1;
        end else begin
            level = LVL_NONE;
        end
    end

endmodule

// File: rtl/int_priority_ctrl.sv
// Three-level nested interrupt controller: captures request edges, picks the
// highest pending level above the running one and tracks handler nesting.
module int_priority_ctrl
    import int_pkg::*;
#(
    parameter logic [31:0] VEC1 = VEC1_DEF,
    parameter logic [31:0] VEC2 = VEC2_DEF,
    parameter logic [31:0] VEC3 = VEC3_DEF
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        inter1,
    input  logic        inter2,
    input  logic        inter3,
    input  logic        ien,
    input  logic        int_ack,
    input  logic        eret,
    output logic        int_req,
    output logic [31:0] int_vec,
    output logic [1:0]  int_level,
    output logic        inter_running1,
    output logic        inter_running2,
    output logic        inter_running3
);

    logic [2:0]  prev_q, prev_d;
    logic [2:0]  pend_q, pend_d;
    logic [2:0]  active_q, active_d;
    logic [2:0]  running_q, running_d;
    logic        int_req_q, int_req_d;
    logic [1:0]  int_level_q, int_level_d;
    logic [31:0] int_vec_q, int_vec_d;

    logic [2:0]  inter_s;
    logic [1:0]  cur_s;
    logic [1:0]  sel_s;
    logic        ack_s;
    logic [2:0]  ack_oh_s;
    logic [2:0]  ret_oh_s;

    int_prio_enc u_cur_enc (
        .mask  (active_q),
        .level (cur_s)
    );

    int_prio_enc u_sel_enc (
        .mask  (pend_q & above_mask(cur_s)),
        .level (sel_s)
    );

    // Next-state for capture, nesting and the registered request outputs.
    always_comb begin
        inter_s  = {inter3, inter2, inter1};
        ack_s    = int_ack & int_req_q;
        ack_oh_s = ack_s ? lvl_onehot(int_level_q) : 3'b000;
        ret_oh_s = eret ? lvl_onehot(cur_s) : 3'b000;

        prev_d   = inter_s;
        // A fresh edge on the level being acked re-arms it (set wins).
        pend_d   = (pend_q & ~ack_oh_s) | (inter_s & ~prev_q);
        active_d = (active_q & ~ret_oh_s) | ack_oh_s;

        running_d = {active_d[2],
                     active_d[1] & ~active_d[2],
                     active_d[0] & ~(active_d[2] | active_d[1])};

        int_req_d   = ien & (sel_s != LVL_NONE) & ~int_ack;
        int_level_d = sel_s;
        case (sel_s)
            LVL1:    int_vec_d = VEC1;
            LVL2:    int_vec_d = VEC2;
            LVL3:    int_vec_d = VEC3;
            default: int_vec_d = 32'h0000_0000;
        endcase
    end

    // State registers; edge history resets high so held lines stay quiet.
    always_ff @(posedge clk) begin
        if (clr) begin
            prev_q      <= 3'b111;
            pend_q      <= 3'b000;
            active_q    <= 3'b000;
            running_q   <= 3'b000;
            int_req_q   <= 1'b0;
            int_level_q <= LVL_NONE;
            int_vec_q   <= 32'h0000_0000;
        end else begin
            prev_q      <= prev_d;
            pend_q      <= pend_d;
            active_q    <= active_d;
            running_q   <= running_d;
            int_req_q   <= int_req_d;
            int_level_q <= int_level_d;
            int_vec_q   <= int_vec_d;
        end
    end

    assign int_req        = int_req_q;
    assign int_level      = int_level_q;
    assign int_vec        = int_vec_q;
    assign inter_running1 = running_q[0];
    assign inter_running2 = running_q[1];
    assign inter_running3 = running_q[2];

endmodule
